universal_shift_reg: RTL

//  Parametrised successor to the lab-board shift register: WIDTH-bit universal shifter with

---
 rtl/ushift_pkg.sv | 29 ++
 rtl/universal_shift_reg_step_gen.sv | 37 +++
 rtl/universal_shift_reg.sv | 117 +++++++++++
 3 files changed

// File: rtl/ushift_pkg.sv
// Shared definitions for the universal shift register and the display-mux decoder.
// Mode encodings and a width-generic bit reversal helper.
package ushift_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ASR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_LOAD = 3'b110;
   localparam logic [2:0] MODE_REV  = 3'b111;

   localparam int BR_MAX_W = 64;

   // Reverses the low w bits of v; callers zero-extend into BR_MAX_W.
   function automatic logic [BR_MAX_W-1:0] bit_reverse(
      input logic [BR_MAX_W-1:0] v,
      input int                  w
   );
      logic [BR_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < BR_MAX_W; i++) begin
         if (i < w) r[i] = v[w-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/universal_shift_reg_step_gen.sv
// Step request generator: button rising-edge detect plus auto-step prescaler.
// step is combinational and consumed at the same clock edge.
module step_gen #(
   parameter int AUTO_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic step_btn,
   input  logic auto_en,
   output logic step
);

   localparam int              CNT_W = $clog2(AUTO_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(AUTO_DIV - 1);

   logic             btn_prev;
   logic [CNT_W-1:0] count;
   logic             btn_rise;
   logic             tick;

   assign btn_rise = step_btn & ~btn_prev;
   assign tick     = auto_en & (count == LAST);
   assign step     = btn_rise | tick;

   // btn_prev resets high so a button held through reset is not a rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_prev <= 1'b1;
         count    <= '0;
      end else begin
         btn_prev <= step_btn;
         if (!auto_en || tick) count <= '0;
         else                  count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with manual/auto stepping and parallel load.
// Optional step counter output enabled by defining USHIFT_STEP_CNT_EN.
module universal_shift_reg
   import ushift_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter int               AUTO_DIV  = 50_000_000,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              AMT_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_btn,
   input  logic             auto_en,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic             ser_in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             step_evt
`ifdef USHIFT_STEP_CNT_EN
   ,
   output logic [15:0]      step_cnt
`endif
);

   localparam logic [WIDTH-1:0] ONES = '1;

   logic             step;
   logic [AMT_W-1:0] k;
   logic [AMT_W-1:0] hi_idx;
   logic [AMT_W-1:0] lo_idx;
   logic [WIDTH-1:0] fill_l;
   logic [WIDTH-1:0] fill_r;
   logic [WIDTH-1:0] nxt_q;
   logic             nxt_ser;

   step_gen #(
      .AUTO_DIV (AUTO_DIV)
   ) u_step_gen (
      .clk      (clk),
      .rst      (rst),
      .step_btn (step_btn),
      .auto_en  (auto_en),
      .step     (step)
   );

   // Effective distance: 0 means 1, oversize clamps to WIDTH-1.
   always_comb begin
      k = amt;
      if (amt == '0)                 k = AMT_W'(1);
      else if (int'(amt) > WIDTH - 1) k = AMT_W'(WIDTH - 1);
   end

   assign hi_idx = AMT_W'(WIDTH - int'(k));
   assign lo_idx = k - AMT_W'(1);
   assign fill_l = ser_in ? ~(ONES << k) : '0;
   assign fill_r = ser_in ? ~(ONES >> k) : '0;

   always_comb begin
      nxt_q   = q;
      nxt_ser = ser_out;
      unique case (mode)
         MODE_HOLD: ;
         MODE_SHL: begin
            nxt_q   = (q << k) | fill_l;
            nxt_ser = q[hi_idx];
         end
         MODE_SHR: begin
            nxt_q   = (q >> k) | fill_r;
            nxt_ser = q[lo_idx];
         end
         MODE_ASR: begin
            nxt_q   = $signed(q) >>> k;
            nxt_ser = q[lo_idx];
         end
         MODE_ROL: begin
            nxt_q   = (q << k) | (q >> hi_idx);
            nxt_ser = q[hi_idx];
         end
         MODE_ROR: begin
            nxt_q   = (q >> k) | (q << hi_idx);
            nxt_ser = q[lo_idx];
         end
         MODE_LOAD: nxt_q = load_val;
         MODE_REV:  nxt_q = WIDTH'(bit_reverse(BR_MAX_W'(q), WIDTH));
      endcase
   end

   // An external load pulse pre-empts and drops a coincident step.
   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= RESET_VAL;
         ser_out  <= 1'b0;
         step_evt <= 1'b0;
      end else begin
         step_evt <= 1'b0;
         if (load) begin
            q <= load_val;
         end else if (step) begin
            q        <= nxt_q;
            ser_out  <= nxt_ser;
            step_evt <= 1'b1;
         end
      end
   end

`ifdef USHIFT_STEP_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)              step_cnt <= '0;
      else if (!load && step) step_cnt <= step_cnt + 16'd1;
   end
`endif

endmodule
